spi_mem_arbiter: RTL and testbench
==================================

Name: spi_mem_arbiter

Overview:
- Sequences the decoded SPI slave command stream (ctrl/address, rx_en/rx_data, tx_en/tx_valid/tx_data, spi_done) onto one single-port RAM.
- Shares that RAM with a local user requester.
- SPI beats cannot stall, so they always have priority; the user port gets idle cycles.
- Sits between spi_slave and the RAM, replacing the loopback FIFO used in bring-up.

Parameters:
- CTRL_WIDTH, 8, width of SPI control byte.
- ADDR_WIDTH, 8, RAM word-address width; depth = 2^ADDR_WIDTH.
- DATA_WIDTH, 8, RAM/SPI data width.
- LEN_WIDTH, 32, width of transfer beat counter.
- CTRL_WRITE, 8'h3a, SPI write command code.
- CTRL_READ, 8'h3b, SPI read command code.
- PROT_TOP, 8'h0f, highest write-protected address (used only with optional feature).

Ports:
- clock  in  1  system clock.
- reset_n  in  1  synchronous reset, active-low.
- spi_ctrl  in  CTRL_WIDTH  command from spi_slave; stable from first beat until spi_done.
- spi_address  in  ADDR_WIDTH  start address from spi_slave; stable like spi_ctrl.
- spi_rx_en  in  1  one-cycle pulse, spi_rx_data valid.
- spi_rx_data  in  DATA_WIDTH  received byte.
- spi_tx_en  in  1  one-cycle pulse, request next tx byte.
- spi_tx_valid  out  1  pulse, spi_tx_data valid.
- spi_tx_data  out  DATA_WIDTH  byte to transmit.
- spi_done  in  1  one-cycle pulse, SPI transaction ended.
- usr_req  in  1  user access request; held until grant.
- usr_we  in  1  1 = write, 0 = read.
- usr_addr  in  ADDR_WIDTH  user address.
- usr_wdata  in  DATA_WIDTH  user write data.
- usr_gnt  out  1  request accepted this cycle.
- usr_rvalid  out  1  pulse, usr_rdata valid.
- usr_rdata  out  DATA_WIDTH  user read data.
- mem_en  out  1  RAM access enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_WIDTH  RAM address.
- mem_wdata  out  DATA_WIDTH  RAM write data.
- mem_rdata  in  DATA_WIDTH  RAM read data, 1-cycle latency after mem_en & ~mem_we.
- busy  out  1  SPI transaction in progress (state != IDLE).
- xfer_cnt  out  LEN_WIDTH  beats completed in current/last SPI transaction.
- cmd_err  out  1  pulse on illegal beat.

Behaviour:
- Reset (reset_n = 0 at clock edge): all outputs 0, state IDLE, pointer 0, xfer_cnt 0. In-flight read responses are discarded. Applies mid-burst.
- spi_beat = spi_rx_en | spi_tx_en.
- RAM port is combinational from the current cycle's winner. Exactly one access per cycle.
- FSM states: IDLE, WRITE, READ.
- IDLE to WRITE: spi_rx_en with spi_ctrl == CTRL_WRITE. The beat uses addr = spi_address; pointer <= spi_address + 1; xfer_cnt <= 1.
- IDLE to READ: spi_tx_en with spi_ctrl == CTRL_READ. Same pointer/xfer_cnt load.
- In WRITE, spi_rx_en: mem write at pointer; pointer += 1; xfer_cnt += 1.
- In READ, spi_tx_en: mem read at pointer; pointer += 1; xfer_cnt += 1.
- Pointer wraps modulo 2^ADDR_WIDTH (0xff + 1 = 0x00). xfer_cnt saturates at all-ones.
- WRITE/READ to IDLE: on spi_done. A beat in the same cycle as spi_done is serviced first. xfer_cnt holds its value until the next transaction start.
- SPI read response: spi_tx_valid is asserted exactly 1 cycle after spi_tx_en, with spi_tx_data = mem_rdata. spi_tx_data holds its value between pulses.
- Illegal beats:
  - rx_en in READ, or tx_en in WRITE.
  - Beat whose ctrl matches neither command.
  - rx_en and tx_en in the same cycle.
- Illegal-beat handling: cmd_err pulse the next cycle; no RAM write; state and pointer unchanged. Any tx_en still gets spi_tx_valid next cycle with data 0, so spi_slave never hangs.
- User port: usr_gnt = usr_req & ~spi_beat (combinational). On grant, mem is driven from usr_*.
- User read: usr_rvalid pulses 1 cycle after grant, usr_rdata = mem_rdata; usr_rdata holds otherwise.
- User accesses are allowed in any state, including mid-burst, in cycles without an SPI beat.
- Continuous SPI beats may starve the user; this is accepted.
- Back-to-back grants are supported at one per cycle.

Optional Feature:
- Macro MEM_ARB_WPROT_EN.
- Defined: SPI writes with address <= PROT_TOP are dropped (mem_en low), cmd_err pulses, pointer and xfer_cnt still advance. User writes are unaffected.
- Undefined: no protection; PROT_TOP ignored.

Test Plan:
- SPI write burst: ctrl 0x3a, address 0x10, four rx_en with 0xA1..0xA4, then spi_done -> RAM[0x10..0x13] = A1..A4, xfer_cnt = 4, busy falls the cycle after spi_done.
- SPI read burst: ctrl 0x3b, address 0x10, four tx_en spaced 3 cycles -> four spi_tx_valid, each 1 cycle after tx_en, data A1..A4.
- Wrap: write burst at address 0xFE, three bytes -> RAM[0xFE], RAM[0xFF], RAM[0x00] written.
- Contention: usr_req write 0x55 to 0x20 held across an rx_en cycle -> usr_gnt low that cycle, high the next; RAM[0x20] = 0x55; SPI byte lands at its own address.
- Illegal: ctrl 0x00 with tx_en -> cmd_err pulse, spi_tx_valid with 0x00, no RAM write. Reset asserted mid-read burst -> no spi_tx_valid afterwards, busy = 0, xfer_cnt = 0.
- With MEM_ARB_WPROT_EN: SPI write 0x77 to address 0x05 -> RAM[0x05] unchanged, cmd_err pulses, xfer_cnt = 1.

Source files
------------

// File: rtl/spi_mem_arbiter.sv
// Arbitrates one single-port RAM between the SPI slave command stream (always wins) and a
// local user port. Define MEM_ARB_WPROT_EN to drop SPI writes at addresses <= PROT_TOP.
module spi_mem_arbiter #(
  parameter int CTRL_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 32,
  parameter logic [CTRL_WIDTH-1:0] CTRL_WRITE = 8'h3a,
  parameter logic [CTRL_WIDTH-1:0] CTRL_READ  = 8'h3b,
  parameter logic [ADDR_WIDTH-1:0] PROT_TOP   = 8'h0f
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [CTRL_WIDTH-1:0] spi_ctrl,
  input  logic [ADDR_WIDTH-1:0] spi_address,
  input  logic                  spi_rx_en,
  input  logic [DATA_WIDTH-1:0] spi_rx_data,
  input  logic                  spi_tx_en,
  output logic                  spi_tx_valid,
  output logic [DATA_WIDTH-1:0] spi_tx_data,
  input  logic                  spi_done,
  input  logic                  usr_req,
  input  logic                  usr_we,
  input  logic [ADDR_WIDTH-1:0] usr_addr,
  input  logic [DATA_WIDTH-1:0] usr_wdata,
  output logic                  usr_gnt,
  output logic                  usr_rvalid,
  output logic [DATA_WIDTH-1:0] usr_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic [LEN_WIDTH-1:0]  xfer_cnt,
  output logic                  cmd_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  tx_pend_q;
  logic                  tx_ok_q;
  logic                  usr_rd_pend_q;
  logic                  cmd_err_q;
  logic [DATA_WIDTH-1:0] tx_hold_q;
  logic [DATA_WIDTH-1:0] usr_hold_q;

  logic                  spi_beat_s;
  logic                  wr_ok_s;
  logic                  rd_ok_s;
  logic                  wr_prot_s;
  logic                  wr_go_s;
  logic                  illegal_s;
  logic                  usr_gnt_s;
  logic [ADDR_WIDTH-1:0] spi_addr_s;
  logic [DATA_WIDTH-1:0] spi_tx_data_s;
  logic [DATA_WIDTH-1:0] usr_rdata_s;

  assign spi_beat_s = spi_rx_en | spi_tx_en;
  assign spi_addr_s = (state_q == ST_IDLE) ? spi_address : ptr_q;

  // A beat is legal only as a single-direction beat whose command matches and does not
  // contradict the direction of a burst already in progress.
  assign wr_ok_s = spi_rx_en & ~spi_tx_en & (spi_ctrl == CTRL_WRITE) & (state_q != ST_READ);
  assign rd_ok_s = spi_tx_en & ~spi_rx_en & (spi_ctrl == CTRL_READ)  & (state_q != ST_WRITE);

`ifdef MEM_ARB_WPROT_EN
  assign wr_prot_s = wr_ok_s & (spi_addr_s <= PROT_TOP);
`else
  assign wr_prot_s = 1'b0;
`endif

  assign wr_go_s   = wr_ok_s & ~wr_prot_s;
  assign illegal_s = (spi_beat_s & ~(wr_ok_s | rd_ok_s)) | wr_prot_s;
  assign usr_gnt_s = reset_n & usr_req & ~spi_beat_s;

  // RAM port steering: SPI beat first, user request in SPI-free cycles
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {ADDR_WIDTH{1'b0}};
    mem_wdata = {DATA_WIDTH{1'b0}};
    if (!reset_n) begin
      mem_en = 1'b0;
    end else if (wr_go_s) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = spi_addr_s;
      mem_wdata = spi_rx_data;
    end else if (rd_ok_s) begin
      mem_en   = 1'b1;
      mem_addr = spi_addr_s;
    end else if (usr_gnt_s) begin
      mem_en    = 1'b1;
      mem_we    = usr_we;
      mem_addr  = usr_addr;
      mem_wdata = usr_wdata;
    end else begin
      mem_en = 1'b0;
    end
  end

  // Burst pointer and saturating beat counter, advanced on every accepted beat
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (wr_ok_s | rd_ok_s) begin
      ptr_d = spi_addr_s + ADDR_WIDTH'(1);
      if (state_q == ST_IDLE) begin
        cnt_d = LEN_WIDTH'(1);
      end else if (cnt_q != {LEN_WIDTH{1'b1}}) begin
        cnt_d = cnt_q + LEN_WIDTH'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Illegal tx beats answer with zero so spi_slave always gets its byte
  assign spi_tx_data_s = tx_pend_q ? (tx_ok_q ? mem_rdata : {DATA_WIDTH{1'b0}}) : tx_hold_q;
  assign usr_rdata_s   = usr_rd_pend_q ? mem_rdata : usr_hold_q;

  // Transaction FSM plus response-tracking registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      ptr_q         <= {ADDR_WIDTH{1'b0}};
      cnt_q         <= {LEN_WIDTH{1'b0}};
      tx_pend_q     <= 1'b0;
      tx_ok_q       <= 1'b0;
      usr_rd_pend_q <= 1'b0;
      cmd_err_q     <= 1'b0;
      tx_hold_q     <= {DATA_WIDTH{1'b0}};
      usr_hold_q    <= {DATA_WIDTH{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (spi_done) begin
            state_q <= ST_IDLE;
          end else if (wr_ok_s) begin
            state_q <= ST_WRITE;
          end else if (rd_ok_s) begin
            state_q <= ST_READ;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_WRITE, ST_READ: begin
          if (spi_done) begin
            state_q <= ST_IDLE;
          end else begin
            state_q <= state_q;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      tx_pend_q     <= spi_tx_en;
      tx_ok_q       <= rd_ok_s;
      usr_rd_pend_q <= usr_gnt_s & ~usr_we;
      cmd_err_q     <= illegal_s;
      if (tx_pend_q) begin
        tx_hold_q <= spi_tx_data_s;
      end else begin
        tx_hold_q <= tx_hold_q;
      end
      if (usr_rd_pend_q) begin
        usr_hold_q <= mem_rdata;
      end else begin
        usr_hold_q <= usr_hold_q;
      end
    end
  end

  assign usr_gnt      = usr_gnt_s;
  assign spi_tx_valid = tx_pend_q;
  assign spi_tx_data  = spi_tx_data_s;
  assign usr_rvalid   = usr_rd_pend_q;
  assign usr_rdata    = usr_rdata_s;
  assign busy         = (state_q != ST_IDLE);
  assign xfer_cnt     = cnt_q;
  assign cmd_err      = cmd_err_q;

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Self-checking bench for spi_mem_arbiter: directed scenarios plus random SPI bursts with
// interleaved user traffic, checked against a transaction-level memory model.
module tb_spi_mem_arbiter;

  localparam logic [7:0] C_WR = 8'h3a;
  localparam logic [7:0] C_RD = 8'h3b;

  logic        clock       = 1'b0;
  logic        reset_n     = 1'b0;
  logic [7:0]  spi_ctrl    = 8'h00;
  logic [7:0]  spi_address = 8'h00;
  logic        spi_rx_en   = 1'b0;
  logic [7:0]  spi_rx_data = 8'h00;
  logic        spi_tx_en   = 1'b0;
  logic        spi_done    = 1'b0;
  logic        usr_req     = 1'b0;
  logic        usr_we      = 1'b0;
  logic [7:0]  usr_addr    = 8'h00;
  logic [7:0]  usr_wdata   = 8'h00;
  logic        spi_tx_valid;
  logic [7:0]  spi_tx_data;
  logic        usr_gnt;
  logic        usr_rvalid;
  logic [7:0]  usr_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        busy;
  logic [31:0] xfer_cnt;
  logic        cmd_err;

  int errors = 0;
  int checks = 0;

  // reference model: expected RAM image, burst direction/next address, beat count, held data
  logic [7:0]  ram     [256];
  logic [7:0]  exp_mem [256];
  int          m_mode = 0;   // 0 none, 1 write burst, 2 read burst
  int          m_next = 0;
  logic [31:0] m_cnt  = 32'd0;
  logic [7:0]  m_txd  = 8'h00;
  logic [7:0]  m_urd  = 8'h00;
  bit          pu_valid = 1'b0;
  bit          pu_we    = 1'b0;
  logic [7:0]  pu_addr  = 8'h00;
  logic [7:0]  pu_wd    = 8'h00;

  always #5 clock = ~clock;

  spi_mem_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .spi_ctrl(spi_ctrl), .spi_address(spi_address),
    .spi_rx_en(spi_rx_en), .spi_rx_data(spi_rx_data),
    .spi_tx_en(spi_tx_en), .spi_tx_valid(spi_tx_valid), .spi_tx_data(spi_tx_data),
    .spi_done(spi_done),
    .usr_req(usr_req), .usr_we(usr_we), .usr_addr(usr_addr), .usr_wdata(usr_wdata),
    .usr_gnt(usr_gnt), .usr_rvalid(usr_rvalid), .usr_rdata(usr_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy(busy), .xfer_cnt(xfer_cnt), .cmd_err(cmd_err)
  );

  // single-port RAM with one-cycle read latency
  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'(i * 37 + 11);
    forever begin
      @(posedge clock);
      if (mem_en === 1'b1) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        else        mem_rdata     <= ram[mem_addr];
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // one clock: drive beat and pending user request, predict, then check registered results
  task automatic do_cycle(input bit rx, input bit tx, input bit done, input logic [7:0] rxd);
    bit beat, gnt, lw, lr, prot, en, we_e, err_n, urv_n, txn;
    logic [7:0] a;
    spi_rx_en = rx; spi_tx_en = tx; spi_done = done; spi_rx_data = rxd;
    usr_req = pu_valid; usr_we = pu_we; usr_addr = pu_addr; usr_wdata = pu_wd;
    #2;
    beat = rx | tx;
    gnt  = pu_valid & ~beat;
    lw   = rx && !tx && (spi_ctrl == C_WR) && (m_mode != 2);
    lr   = tx && !rx && (spi_ctrl == C_RD) && (m_mode != 1);
    a    = (m_mode == 0) ? spi_address : 8'(m_next);
    prot = 1'b0;
`ifdef MEM_ARB_WPROT_EN
    prot = lw && (a <= 8'h0f);
`endif
    en   = (lw && !prot) || lr || gnt;
    we_e = (lw && !prot) || (gnt && pu_we);
    check_val("usr_gnt", usr_gnt, gnt);
    check_val("mem_en", mem_en, en);
    if (en) begin
      check_val("mem_we", mem_we, we_e);
      check_val("mem_addr", mem_addr, (lw || lr) ? a : pu_addr);
      if (we_e) check_val("mem_wdata", mem_wdata, lw ? rxd : pu_wd);
    end
    err_n = (beat && !(lw || lr)) || prot;
    urv_n = gnt && !pu_we;
    txn   = tx;
    if (tx)    m_txd = lr ? exp_mem[a] : 8'h00;
    if (urv_n) m_urd = exp_mem[pu_addr];
    if (lw && !prot)  exp_mem[a] = rxd;
    if (gnt && pu_we) exp_mem[pu_addr] = pu_wd;
    if (lw || lr) begin
      if (m_mode == 0) begin
        m_mode = lw ? 1 : 2;
        m_cnt  = 32'd1;
      end else if (m_cnt != 32'hffff_ffff) begin
        m_cnt = m_cnt + 32'd1;
      end
      m_next = (int'(a) + 1) % 256;
    end
    if (done) m_mode = 0;
    if (gnt) pu_valid = 1'b0;
    @(posedge clock); #1;
    spi_rx_en = 1'b0; spi_tx_en = 1'b0; spi_done = 1'b0; usr_req = 1'b0;
    check_val("spi_tx_valid", spi_tx_valid, txn);
    check_val("spi_tx_data", spi_tx_data, m_txd);
    check_val("cmd_err", cmd_err, err_n);
    check_val("usr_rvalid", usr_rvalid, urv_n);
    check_val("usr_rdata", usr_rdata, m_urd);
    check_val("busy", busy, (m_mode != 0));
    check_val("xfer_cnt", xfer_cnt, m_cnt);
  endtask

  task automatic rand_cycle(input bit rx, input bit tx, input bit done, input logic [7:0] rxd);
    if (!pu_valid && ($urandom_range(0, 2) == 0)) begin
      pu_valid = 1'b1;
      pu_we    = 1'($urandom_range(0, 1));
      pu_addr  = 8'($urandom);
      pu_wd    = 8'($urandom);
    end
    do_cycle(rx, tx, done, rxd);
  endtask

  task automatic apply_reset(input bit with_tx);
    reset_n = 1'b0; spi_tx_en = with_tx;
    usr_req = 1'b1; usr_we = 1'b0; usr_addr = 8'h10;
    #2;
    check_val("rst_usr_gnt", usr_gnt, 1'b0);
    check_val("rst_mem_en", mem_en, 1'b0);
    @(posedge clock); #1;
    spi_tx_en = 1'b0; usr_req = 1'b0;
    m_mode = 0; m_cnt = 32'd0; m_txd = 8'h00; m_urd = 8'h00; pu_valid = 1'b0;
    check_val("rst_tx_valid", spi_tx_valid, 1'b0);
    check_val("rst_tx_data", spi_tx_data, 8'h00);
    check_val("rst_cmd_err", cmd_err, 1'b0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_xfer_cnt", xfer_cnt, 32'd0);
    check_val("rst_usr_rvalid", usr_rvalid, 1'b0);
    check_val("rst_usr_rdata", usr_rdata, 8'h00);
    @(posedge clock); #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int kind, nb, gap, r;
    bit rx, tx, dn;
    logic [7:0] prior;
    for (int i = 0; i < 256; i++) exp_mem[i] = 8'(i * 37 + 11);

    apply_reset(1'b0);

    // write burst A1..A4 at 0x10
    spi_ctrl = C_WR; spi_address = 8'h10;
    for (int i = 0; i < 4; i++) begin
      do_cycle(1'b1, 1'b0, 1'b0, 8'(8'hA1 + i));
      do_cycle(1'b0, 1'b0, 1'b0, 8'h00);
    end
    check_val("wr_busy", busy, 1'b1);
    do_cycle(1'b0, 1'b0, 1'b1, 8'h00);
    check_val("wr_busy_fall", busy, 1'b0);
    check_val("wr_cnt", xfer_cnt, 32'd4);
    for (int i = 0; i < 4; i++) check_val("wr_ram", ram[8'h10 + i], 8'(8'hA1 + i));

    // read burst back, tx_en spaced three cycles
    spi_ctrl = C_RD; spi_address = 8'h10;
    for (int i = 0; i < 4; i++) begin
      do_cycle(1'b0, 1'b1, 1'b0, 8'h00);
      check_val("rd_data", spi_tx_data, 8'(8'hA1 + i));
      do_cycle(1'b0, 1'b0, 1'b0, 8'h00);
      do_cycle(1'b0, 1'b0, 1'b0, 8'h00);
    end
    do_cycle(1'b0, 1'b0, 1'b1, 8'h00);

    // address wrap 0xFE -> 0x00, done with the last beat
    spi_ctrl = C_WR; spi_address = 8'hFE;
    do_cycle(1'b1, 1'b0, 1'b0, 8'hB0);
    do_cycle(1'b1, 1'b0, 1'b0, 8'hB1);
    do_cycle(1'b1, 1'b0, 1'b1, 8'hB2);
    check_val("wrap_fe", ram[8'hFE], 8'hB0);
    check_val("wrap_ff", ram[8'hFF], 8'hB1);
    check_val("wrap_00", ram[8'h00], 8'hB2);
    check_val("wrap_cnt", xfer_cnt, 32'd3);

    // user write held across an SPI beat
    spi_ctrl = C_WR; spi_address = 8'h30;
    pu_valid = 1'b1; pu_we = 1'b1; pu_addr = 8'h20; pu_wd = 8'h55;
    do_cycle(1'b1, 1'b0, 1'b0, 8'hC3);
    do_cycle(1'b0, 1'b0, 1'b1, 8'h00);
    check_val("cont_usr", ram[8'h20], 8'h55);
    check_val("cont_spi", ram[8'h30], 8'hC3);

    // unknown command with tx_en
    spi_ctrl = 8'h00; spi_address = 8'h40; prior = ram[8'h40];
    do_cycle(1'b0, 1'b1, 1'b0, 8'h00);
    check_val("ill_cmd_err", cmd_err, 1'b1);
    check_val("ill_tx_valid", spi_tx_valid, 1'b1);
    check_val("ill_tx_data", spi_tx_data, 8'h00);
    check_val("ill_ram", ram[8'h40], prior);
    do_cycle(1'b0, 1'b0, 1'b1, 8'h00);

`ifdef MEM_ARB_WPROT_EN
    spi_ctrl = C_WR; spi_address = 8'h05; prior = ram[8'h05];
    do_cycle(1'b1, 1'b0, 1'b1, 8'h77);
    check_val("prot_ram", ram[8'h05], prior);
    check_val("prot_cmd_err", cmd_err, 1'b1);
    check_val("prot_cnt", xfer_cnt, 32'd1);
`endif

    // reset in the middle of a read burst, with a tx_en on the reset edge
    spi_ctrl = C_RD; spi_address = 8'h10;
    do_cycle(1'b0, 1'b1, 1'b0, 8'h00);
    do_cycle(1'b0, 1'b0, 1'b0, 8'h00);
    apply_reset(1'b1);
    do_cycle(1'b0, 1'b0, 1'b0, 8'h00);

    // random bursts with interleaved user traffic
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 9);
      nb   = $urandom_range(1, 6);
      if (kind < 4)      spi_ctrl = C_WR;
      else if (kind < 8) spi_ctrl = C_RD;
      else               spi_ctrl = 8'($urandom_range(8'h40, 8'hff));
      spi_address = 8'($urandom);
      for (int b = 0; b < nb; b++) begin
        gap = $urandom_range(0, 3);
        for (int g = 0; g < gap; g++) rand_cycle(1'b0, 1'b0, 1'b0, 8'h00);
        r  = $urandom_range(0, 9);
        rx = (kind < 4) || ((kind >= 8) && (r > 4));
        tx = !rx;
        if (r == 0)      begin rx = 1'b1; tx = 1'b1; end
        else if (r == 1) begin rx = !rx;  tx = !tx;  end
        dn = (b == nb - 1) && ($urandom_range(0, 1) == 1);
        rand_cycle(rx, tx, dn, 8'($urandom));
        if ((b == nb - 1) && !dn) rand_cycle(1'b0, 1'b0, 1'b1, 8'h00);
      end
      rand_cycle(1'b0, 1'b0, 1'b0, 8'h00);
    end
    do_cycle(1'b0, 1'b0, 1'b0, 8'h00);
    do_cycle(1'b0, 1'b0, 1'b0, 8'h00);

    for (int i = 0; i < 256; i++) check_val("ram_final", ram[i], exp_mem[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
